ofdm_stream_coder: RTL and testbench

//  Parametrised, registered coder stage for the OFDM TX/RX bit path. It replaces the

---
 rtl/ofdm_coder_pkg.sv | 39 +++
 rtl/ofdm_skid_buf.sv | 56 +++++
 rtl/ofdm_stream_coder.sv | 87 ++++++++
 tb/tb_ofdm_stream_coder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_coder_pkg.sv
// rtl/ofdm_coder_pkg.sv - shared types, constants and the scrambler step function for the OFDM coder
package ofdm_coder_pkg;

    typedef enum logic {
        MODE_BYPASS   = 1'b0,
        MODE_SCRAMBLE = 1'b1
    } coder_mode_e;

    localparam int LFSR_W     = 7;
    // Widest data beat the scrambler function can code in one call.
    localparam int MAX_DATA_W = 64;

    typedef struct packed {
        logic [LFSR_W-1:0]     state;
        logic [MAX_DATA_W-1:0] coded;
    } scr_res_t;

    // Unrolled x^7+x^4+1 additive scrambler over data_w bits, bit 0 first.
    // Bits at and above data_w are returned as zero and leave the state alone.
    function automatic scr_res_t lfsr_scramble(input logic [LFSR_W-1:0]     state,
                                               input logic [MAX_DATA_W-1:0] data,
                                               input int                    data_w);
        scr_res_t          r;
        logic              fb;
        logic [LFSR_W-1:0] s;
        s       = state;
        r.coded = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w) begin
                fb         = s[6] ^ s[3];
                r.coded[i] = data[i] ^ fb;
                s          = {s[5:0], fb};
            end
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/ofdm_skid_buf.sv
// rtl/ofdm_skid_buf.sv - 2-entry valid/ready buffer with registered in_ready
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data (W bits) upstream;
//        out_valid/out_ready/out_data (W bits) downstream.
module ofdm_skid_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         in_ready_q;
    logic         push;
    logic         pop;

    assign push      = in_valid && in_ready_q;
    assign pop       = (cnt_q != 2'd0) && out_ready;
    assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    assign in_ready  = in_ready_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q      <= cnt_d;
            // Registered ready: drop only once the post-update occupancy is full.
            in_ready_q <= (cnt_d != 2'd2);
        end
    end

endmodule

// File: rtl/ofdm_stream_coder.sv
// rtl/ofdm_stream_coder.sv - valid/ready bypass or 802.11a scrambler stage with per-frame mode and seed
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_sof input stream;
//        in_mode, in_seed_ld, in_seed frame controls sampled on SOF;
//        out_valid/out_ready/out_data/out_sof output stream.
module ofdm_stream_coder
    import ofdm_coder_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter logic [LFSR_W-1:0] SEED   = 7'h7F
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_mode,
    input  logic              in_seed_ld,
    input  logic [LFSR_W-1:0] in_seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    coder_mode_e       mode_q;
    coder_mode_e       mode_d;

    logic              in_fire;
    coder_mode_e       cur_mode;
    logic [LFSR_W-1:0] cur_state;
    logic [LFSR_W-1:0] next_state;
    logic [DATA_W-1:0] coded;
    scr_res_t          res;
    logic              unused_res_bits;

    assign in_fire = in_valid && in_ready;

    // An SOF beat is coded with the mode and seed it carries, not the latched ones.
    always_comb begin
        cur_mode  = in_sof ? coder_mode_e'(in_mode) : mode_q;
        cur_state = in_sof ? (in_seed_ld ? in_seed : SEED) : lfsr_q;
        res       = lfsr_scramble(cur_state, MAX_DATA_W'(in_data), DATA_W);
        if (cur_mode == MODE_SCRAMBLE) begin
            coded      = res.coded[DATA_W-1:0];
            next_state = res.state;
        end else begin
            coded      = in_data;
            next_state = cur_state;
        end
        mode_d = mode_q;
        lfsr_d = lfsr_q;
        if (in_fire) begin
            mode_d = cur_mode;
            lfsr_d = next_state;
        end
    end

    // Coded bits above DATA_W are always zero.
    assign unused_res_bits = ^res.coded;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
            mode_q <= MODE_BYPASS;
        end else begin
            lfsr_q <= lfsr_d;
            mode_q <= mode_d;
        end
    end

    ofdm_skid_buf #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_sof, coded}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_sof, out_data})
    );

endmodule

// File: tb/tb_ofdm_stream_coder.sv
// tb/tb_ofdm_stream_coder.sv - scoreboard bench for ofdm_stream_coder (DATA_W=8 and DATA_W=1)
module tb_ofdm_stream_coder;

    typedef struct {
        logic       sof;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, in_sof, in_mode, in_seed_ld;
    logic [7:0] in_data;
    logic [6:0] in_seed;
    logic       out_valid, out_ready, out_sof;
    logic [7:0] out_data;

    logic       in_valid1, in_ready1, in_sof1, in_mode1, in_seed_ld1, in_data1;
    logic [6:0] in_seed1;
    logic       out_valid1, out_ready1, out_sof1, out_data1;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];
    exp_t q1[$];
    bit   hist[$];
    bit   m_mode;
    bit   rand_rdy = 0;
    bit   hold_pending = 0;
    exp_t held;

    ofdm_stream_coder #(.DATA_W(8), .SEED(7'h7F)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .in_mode(in_mode), .in_seed_ld(in_seed_ld), .in_seed(in_seed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof)
    );

    ofdm_stream_coder #(.DATA_W(1), .SEED(7'h7F)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_sof(in_sof1),
        .in_mode(in_mode1), .in_seed_ld(in_seed_ld1), .in_seed(in_seed1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_sof(out_sof1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: the scrambler bit stream as the recurrence x[n] = x[n-7] ^ x[n-4],
    // with the seed providing the seven bits before the frame (bit 6 oldest).
    function automatic void m_sof(input bit mode, input logic [6:0] seed);
        m_mode = mode;
        hist.delete();
        for (int i = 6; i >= 0; i--) hist.push_back(seed[i]);
    endfunction

    function automatic logic [7:0] m_code(input logic [7:0] d);
        logic [7:0] r;
        bit         b;
        if (!m_mode) return d;
        for (int i = 0; i < 8; i++) begin
            b = hist[hist.size() - 7] ^ hist[hist.size() - 4];
            hist.push_back(b);
            void'(hist.pop_front());
            r[i] = d[i] ^ b;
        end
        return r;
    endfunction

    task automatic send(input logic sof, input logic mode, input logic ld, input logic [6:0] seed,
                        input logic [7:0] data, input logic use_exp, input logic [7:0] exp_in,
                        output logic [7:0] exp_out);
        logic rdy;
        int   w;
        exp_t e;
        exp_out    = 8'h00;
        in_valid   = 1'b1;
        in_sof     = sof;
        in_mode    = mode;
        in_seed_ld = ld;
        in_seed    = seed;
        in_data    = data;
        w   = 0;
        rdy = 1'b0;
        while (!rdy && w < 1000) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            w++;
        end
        if (!rdy) begin
            chk("accept_timeout", 32'(rdy), 32'd1);
        end else begin
            if (sof) m_sof(mode, ld ? seed : 7'h7F);
            e.data = m_code(data);
            if (use_exp) e.data = exp_in;
            e.sof = sof;
            q.push_back(e);
            exp_out = e.data;
        end
        #1;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_data    = 8'($urandom);
        in_mode    = 1'($urandom);
        in_seed_ld = 1'($urandom);
        in_seed    = 7'($urandom);
    endtask

    task automatic sm(input logic sof, input logic mode, input logic ld, input logic [6:0] seed,
                      input logic [7:0] data);
        logic [7:0] dummy;
        send(sof, mode, ld, seed, data, 1'b0, 8'h00, dummy);
    endtask

    task automatic se(input logic sof, input logic mode, input logic ld, input logic [6:0] seed,
                      input logic [7:0] data, input logic [7:0] exp);
        logic [7:0] dummy;
        send(sof, mode, ld, seed, data, 1'b1, exp, dummy);
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops on every transfer, and checks held outputs stay stable under stall.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
        end else if (out_valid) begin
            if (hold_pending) begin
                chk("hold_data", 32'(out_data), 32'(held.data));
                chk("hold_sof", 32'(out_sof), 32'(held.sof));
            end
            if (out_ready) begin
                hold_pending = 0;
                if (q.size() == 0) begin
                    chk("unexpected_output", 32'(q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_sof", 32'(out_sof), 32'(e.sof));
                end
            end else begin
                hold_pending = 1;
                held.data = out_data;
                held.sof  = out_sof;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_output", 32'(q1.size()), 32'd1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("w1_out_data", 32'(out_data1), 32'(e.data[0]));
                chk("w1_out_sof", 32'(out_sof1), 32'(e.sof));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] arr [256];
        logic [7:0] cod [256];
        logic [6:0] s;
        logic [15:0] seq;
        logic        d1;
        int          len;
        logic        md, ld;

        rst = 1'b1;
        in_valid = 0; in_sof = 0; in_mode = 0; in_seed_ld = 0; in_seed = 0; in_data = 0;
        in_valid1 = 0; in_sof1 = 0; in_mode1 = 0; in_seed_ld1 = 0; in_seed1 = 0; in_data1 = 0;
        out_ready = 1'b1;
        out_ready1 = 1'b1;
        m_sof(1'b0, 7'h7F);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_sof", 32'(out_sof), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Bypass, with one-cycle latency observed directly.
        se(1, 0, 0, 7'h00, 8'hA5, 8'hA5);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("latency_data", 32'(out_data), 32'hA5);
        se(0, 0, 0, 7'h00, 8'h3C, 8'h3C);

        // Scramble from the default seed, then descramble the result.
        se(1, 1, 0, 7'h55, 8'h00, 8'h70);
        se(0, 0, 0, 7'h00, 8'h00, 8'h4F);
        se(1, 1, 0, 7'h00, 8'h70, 8'h00);
        se(0, 1, 1, 7'h11, 8'h4F, 8'h00);
        drain();

        // 256-byte round trip under random backpressure.
        rand_rdy = 1;
        s = 7'($urandom_range(1, 127));
        for (int i = 0; i < 256; i++) begin
            arr[i] = 8'($urandom);
            send(i == 0, 1, 1, s, arr[i], 1'b0, 8'h00, cod[i]);
        end
        for (int i = 0; i < 256; i++) se(i == 0, 1, 1, s, cod[i], arr[i]);
        rand_rdy = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // Backpressure: two beats accepted, then in_ready falls.
        out_ready = 1'b0;
        fork
            begin
                se(1, 1, 0, 7'h00, 8'h00, 8'h70);
                se(0, 0, 0, 7'h00, 8'h00, 8'h4F);
                sm(0, 0, 0, 7'h00, 8'h00);
                sm(0, 0, 0, 7'h00, 8'h00);
            end
        join_none
        repeat (3) @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data_first", 32'(out_data), 32'h70);
        repeat (4) @(negedge clk);
        chk("bp_in_ready_still_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait fork;
        drain();

        // Mid-frame SOF reseeds to all ones.
        sm(1, 1, 1, 7'h2A, 8'h00);
        sm(0, 0, 0, 7'h00, 8'h00);
        sm(0, 0, 0, 7'h00, 8'h00);
        se(1, 1, 1, 7'h7F, 8'h00, 8'h70);
        drain();

        // Reset with two beats buffered.
        out_ready = 1'b0;
        sm(0, 0, 0, 7'h00, 8'($urandom));
        sm(0, 0, 0, 7'h00, 8'($urandom));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_sof", 32'(out_sof), 32'd0);
        q.delete();
        m_sof(1'b0, 7'h7F);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        d1 = 1'b0;
        se(0, 1, 1, 7'h33, 8'hC3, 8'hC3);
        drain();

        // Random frames: random mode, seed source, seed and length.
        rand_rdy = 1;
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 20);
            md  = 1'($urandom);
            ld  = 1'($urandom);
            s   = 7'($urandom_range(1, 127));
            for (int b = 0; b < len; b++) sm(b == 0, md, ld, s, 8'($urandom));
        end
        rand_rdy = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        // DATA_W=1 instance: 802.11a sequence from the all-ones seed, bit 0 first.
        seq = 16'h4F70;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            exp_t e;
            d1 = 1'($urandom);
            in_valid1 = 1'b1; in_sof1 = (i == 0); in_mode1 = 1'b1;
            in_seed_ld1 = 1'b0; in_seed1 = 7'h00; in_data1 = d1;
            @(negedge clk);
            chk("w1_in_ready", 32'(in_ready1), 32'd1);
            @(posedge clk);
            e.sof = (i == 0);
            e.data = {7'd0, d1 ^ seq[i]};
            q1.push_back(e);
            #1;
        end
        in_valid1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("w1_queue_empty", 32'(q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
